// File: rtl/sdram_arb_pkg.sv
// Shared SDRAM bus widths and the arbiter state encoding, imported by the
// arbiter, the SDRAM controller and the draw path.
package sdram_arb_pkg;

  localparam int SDRAM_ADDR_W = 26;
  localparam int SDRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/sdram_arb_watchdog.sv
// Transaction watchdog for sdram_bus_arbiter: reloads while the bus is idle,
// counts bus-owned cycles and flags expiry on the TIMEOUT_CYCLES-th one (BUS_TIMEOUT_EN only).
`ifdef BUS_TIMEOUT_EN
module sdram_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == CNT_LAST);

endmodule
`endif

// File: rtl/sdram_bus_arbiter.sv
// Two-port SDRAM bus arbiter: scan-out reads win, bounded by a read streak so draw
// writes are never starved. Optional watchdog under macro BUS_TIMEOUT_EN.
module sdram_bus_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MAX_RD_STREAK  = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                    clk,
  input  logic                    Reset_n,
  input  logic                    rd_req,
  input  logic [SDRAM_ADDR_W-1:0] rd_addr,
  output logic [SDRAM_DATA_W-1:0] rd_data,
  output logic                    rd_ack,
  input  logic                    wr_req,
  input  logic [SDRAM_ADDR_W-1:0] wr_addr,
  input  logic [SDRAM_DATA_W-1:0] wr_data,
  output logic                    wr_ack,
  output logic [SDRAM_ADDR_W-1:0] ext_address,
  output logic                    ext_read,
  output logic                    ext_write,
  output logic [SDRAM_DATA_W-1:0] ext_write_data,
  input  logic [SDRAM_DATA_W-1:0] ext_read_data,
  input  logic                    ext_acknowledge,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int STREAK_W = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_RD_STREAK);

  arb_state_t              state_q, state_d;
  logic [STREAK_W-1:0]     streak_q, streak_d;
  logic [SDRAM_ADDR_W-1:0] ext_address_q, ext_address_d;
  logic [SDRAM_DATA_W-1:0] ext_write_data_q, ext_write_data_d;
  logic [SDRAM_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                    ext_read_q, ext_read_d;
  logic                    ext_write_q, ext_write_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    wr_ack_q, wr_ack_d;
  logic                    busy_q, busy_d;
  logic                    grant_wr;
  logic                    expire;
  logic                    finish;

`ifdef BUS_TIMEOUT_EN
  logic timeout_err_q, timeout_err_d;

  sdram_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (Reset_n),
    .load  (state_q == IDLE),
    .en    ((state_q == RD) || (state_q == WR)),
    .expire(expire)
  );

  assign timeout_err = timeout_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
  assign expire      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // A write wins only when reads are absent or the read streak has hit its cap.
  assign grant_wr = wr_req && (!rd_req || (streak_q == STREAK_MAX));
  assign finish   = ext_acknowledge || expire;

  always_comb begin
    state_d          = state_q;
    streak_d         = streak_q;
    ext_address_d    = ext_address_q;
    ext_write_data_d = ext_write_data_q;
    rd_data_d        = rd_data_q;
    ext_read_d       = 1'b0;
    ext_write_d      = 1'b0;
    rd_ack_d         = 1'b0;
    wr_ack_d         = 1'b0;
`ifdef BUS_TIMEOUT_EN
    timeout_err_d    = timeout_err_q || (((state_q == RD) || (state_q == WR)) && expire && !ext_acknowledge);
`endif
    unique case (state_q)
      IDLE: begin
        if (!wr_req) streak_d = '0;
        if (grant_wr) begin
          state_d          = WR;
          ext_address_d    = wr_addr;
          ext_write_data_d = wr_data;
          ext_write_d      = 1'b1;
          streak_d         = '0;
        end else if (rd_req) begin
          state_d       = RD;
          ext_address_d = rd_addr;
          ext_read_d    = 1'b1;
          if (wr_req && (streak_q != STREAK_MAX)) streak_d = streak_q + 1'b1;
        end
      end
      RD: begin
        if (finish) begin
          state_d   = DONE;
          rd_ack_d  = 1'b1;
          rd_data_d = ext_acknowledge ? ext_read_data : '0;
        end else begin
          ext_read_d = 1'b1;
        end
      end
      WR: begin
        if (finish) begin
          state_d  = DONE;
          wr_ack_d = 1'b1;
        end else begin
          ext_write_d = 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q          <= IDLE;
      streak_q         <= '0;
      ext_address_q    <= '0;
      ext_write_data_q <= '0;
      rd_data_q        <= '0;
      ext_read_q       <= 1'b0;
      ext_write_q      <= 1'b0;
      rd_ack_q         <= 1'b0;
      wr_ack_q         <= 1'b0;
      busy_q           <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      timeout_err_q    <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      streak_q         <= streak_d;
      ext_address_q    <= ext_address_d;
      ext_write_data_q <= ext_write_data_d;
      rd_data_q        <= rd_data_d;
      ext_read_q       <= ext_read_d;
      ext_write_q      <= ext_write_d;
      rd_ack_q         <= rd_ack_d;
      wr_ack_q         <= wr_ack_d;
      busy_q           <= busy_d;
`ifdef BUS_TIMEOUT_EN
      timeout_err_q    <= timeout_err_d;
`endif
    end
  end

  assign ext_address    = ext_address_q;
  assign ext_write_data = ext_write_data_q;
  assign ext_read       = ext_read_q;
  assign ext_write      = ext_write_q;
  assign rd_data        = rd_data_q;
  assign rd_ack         = rd_ack_q;
  assign wr_ack         = wr_ack_q;
  assign busy           = busy_q;

endmodule
